ahb2apb_bridge_mp: RTL and testbench

Parametrised AHB-Lite-to-APB3 bridge. It supersedes the fixed single-decode bridge with configurable address/data width and slave count, and adds PREADY wait states, PSLVERR-to-HRESP error mapping, decode-miss errors and an access timeout. It sits between the AHB master and NUM_SLAVES APB slaves, and drives one-hot Pselx from a base/stride address map.

---
 rtl/bridge_pkg.sv | 38 +++
 rtl/apb_addr_decoder.sv | 27 ++
 rtl/ahb2apb_bridge_mp.sv | 184 ++++++++++++++++++
 tb/tb_ahb2apb_bridge_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared encodings for the parametrised AHB-Lite to APB3 bridge: AHB
// transfer/response codes, the bridge state enum and small state helpers.
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    // States in which the bridge drives Hreadyout high and can accept a new transfer.
    function automatic logic state_is_ready(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR2);
    endfunction

    // States in which the AHB response is ERROR.
    function automatic logic state_is_error(input state_t s);
        return (s == ST_ERR1) || (s == ST_ERR2);
    endfunction

    // States in which the addressed APB slave is selected.
    function automatic logic state_is_selected(input state_t s);
        return (s == ST_SETUP) || (s == ST_ACCESS);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational base/stride address decoder: a hit when the address falls in
// one of NUM_SLAVES equally sized windows starting at BASE_ADDR, plus the
// index of that window.
module apb_addr_decoder #(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_SLAVES = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                SLV_BITS   = 12,
    localparam int               IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0] Haddr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // One bit wider than the address so a window ending at the top of the
    // address space does not wrap.
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR}
                                      + ((ADDR_W+1)'(NUM_SLAVES) << SLV_BITS);

    logic [ADDR_W-1:0] w_offset;

    assign w_offset = Haddr - BASE_ADDR;
    assign hit      = ({1'b0, Haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, Haddr} < LIMIT);
    assign idx      = IDX_W'(w_offset >> SLV_BITS);

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// Parametrised AHB-Lite to APB3 bridge with multi-slave decode, PREADY wait
// states, PSLVERR and decode-miss error responses, and an ACCESS timeout.
// All outputs are registered; they are loaded from the next state so they
// line up with the state they describe.
module ahb2apb_bridge_mp
    import bridge_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SLAVES = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                SLV_BITS   = 12,
    parameter int                TIMEOUT    = 16
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    input  logic                         Hwrite,
    input  logic                         Hreadyin,
    input  logic [1:0]                   Htrans,
    input  logic [ADDR_W-1:0]            Haddr,
    input  logic [DATA_W-1:0]            Hwdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] Prdata,
    input  logic [NUM_SLAVES-1:0]        Pready,
    input  logic [NUM_SLAVES-1:0]        Pslverr,
    output logic [DATA_W-1:0]            Hrdata,
    output logic [1:0]                   Hresp,
    output logic                         Hreadyout,
    output logic [NUM_SLAVES-1:0]        Pselx,
    output logic                         Penable,
    output logic                         Pwrite,
    output logic [ADDR_W-1:0]            Paddr,
    output logic [DATA_W-1:0]            Pwdata
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT > 0);

    // Slave index to one-hot select vector.
    function automatic logic [NUM_SLAVES-1:0] idx_to_onehot(input logic [IDX_W-1:0] i_idx);
        logic [NUM_SLAVES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            oh[i] = (i_idx == IDX_W'(i));
        end
        return oh;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_dec_idx;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  w_valid;
    logic [NUM_SLAVES-1:0] w_sel_oh;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_W-1:0]     w_sel_rdata;
    logic                  w_capture_rd;
    logic                  w_timeout;

    logic [DATA_W-1:0]     r_hrdata;
    logic [1:0]            r_hresp;
    logic                  r_hreadyout;
    logic [NUM_SLAVES-1:0] r_pselx;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_W-1:0]     r_paddr;
    logic [DATA_W-1:0]     r_pwdata;

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .SLV_BITS   (SLV_BITS)
    ) u_decoder (
        .Haddr (Haddr),
        .hit   (w_hit),
        .idx   (w_dec_idx)
    );

    // A transfer is only taken when the bridge itself is signalling ready.
    assign w_valid   = Hreadyin & Htrans[1] & r_hreadyout;
    assign w_idx_nxt = w_valid ? w_dec_idx : r_idx;
    assign w_sel_oh  = idx_to_onehot(r_idx);

    // Route the addressed slave's ready, error and read data.
    always_comb begin
        w_sel_ready = |(Pready & w_sel_oh);
        w_sel_err   = |(Pslverr & w_sel_oh);
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_rdata = w_sel_rdata | (Prdata[i*DATA_W +: DATA_W] & {DATA_W{w_sel_oh[i]}});
        end
        w_timeout    = TIMEOUT_EN & (r_wait_cnt == CNT_LAST);
        w_capture_rd = (r_state == ST_ACCESS) & w_sel_ready & ~w_sel_err & ~r_pwrite;
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (w_valid && !w_hit) begin
                    w_state_nxt = ST_ERR1;
                end else if (w_valid && Hwrite) begin
                    w_state_nxt = ST_WDATA;
                end else if (w_valid) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WDATA:  w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_sel_ready && w_sel_err) begin
                    w_state_nxt = ST_ERR1;
                end else if (w_sel_ready) begin
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR1;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ERR1:   w_state_nxt = ST_ERR2;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State, wait counter and registered outputs; reset abandons any transfer.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_hrdata    <= '0;
            r_hresp     <= HRESP_OKAY;
            r_hreadyout <= 1'b1;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= state_is_ready(w_state_nxt);
            r_hresp     <= state_is_error(w_state_nxt) ? HRESP_ERROR : HRESP_OKAY;
            r_pselx     <= state_is_selected(w_state_nxt) ? idx_to_onehot(w_idx_nxt)
                                                          : {NUM_SLAVES{1'b0}};
            r_penable   <= (w_state_nxt == ST_ACCESS);
            if (w_valid) begin
                r_idx    <= w_dec_idx;
                r_paddr  <= Haddr;
                r_pwrite <= Hwrite;
            end
            if (r_state == ST_WDATA) begin
                r_pwdata <= Hwdata;
            end
            if (w_capture_rd) begin
                r_hrdata <= w_sel_rdata;
            end
            if (w_state_nxt == ST_SETUP) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    assign Hrdata    = r_hrdata;
    assign Hresp     = r_hresp;
    assign Hreadyout = r_hreadyout;
    assign Pselx     = r_pselx;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Directed bench for ahb2apb_bridge_mp: a per-cycle vector table (inputs for
// one cycle, outputs expected in the following cycle) plus a hand-written
// write-miss sequence. DUT built with TIMEOUT=4.
module tb_ahb2apb_bridge_mp;

    logic         Hclk = 1'b0;
    logic         Hreset;
    logic         Hwrite;
    logic         Hreadyin;
    logic [1:0]   Htrans;
    logic [31:0]  Haddr;
    logic [31:0]  Hwdata;
    logic [95:0]  Prdata;
    logic [2:0]   Pready;
    logic [2:0]   Pslverr;
    logic [31:0]  Hrdata;
    logic [1:0]   Hresp;
    logic         Hreadyout;
    logic [2:0]   Pselx;
    logic         Penable;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;

    int checks   = 0;
    int failures = 0;

    always #5 Hclk = ~Hclk;

    ahb2apb_bridge_mp #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .NUM_SLAVES (3),
        .BASE_ADDR  (32'h8000_0000),
        .SLV_BITS   (12),
        .TIMEOUT    (4)
    ) dut (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Hreadyout (Hreadyout),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [2:0]  pready;
        logic [2:0]  pslverr;
        logic        e_ready;
        logic [1:0]  e_resp;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic [31:0] e_hrdata;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
    } vec_t;

    localparam int NV = 45;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] htrans, input logic hwrite,
        input logic [31:0] haddr, input logic [31:0] hwdata,
        input logic [2:0] pready, input logic [2:0] pslverr,
        input logic e_ready, input logic [1:0] e_resp, input logic [2:0] e_psel,
        input logic e_pen, input logic [31:0] e_hrdata, input logic [31:0] e_paddr,
        input logic e_pwrite, input logic [31:0] e_pwdata);
        vec_t v;
        v.rst = rst; v.htrans = htrans; v.hwrite = hwrite; v.haddr = haddr;
        v.hwdata = hwdata; v.pready = pready; v.pslverr = pslverr;
        v.e_ready = e_ready; v.e_resp = e_resp; v.e_psel = e_psel; v.e_pen = e_pen;
        v.e_hrdata = e_hrdata; v.e_paddr = e_paddr; v.e_pwrite = e_pwrite;
        v.e_pwdata = e_pwdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        int n;
        Hreset   = 1'b1;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Prdata   = {32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
        Pready   = 3'b111;
        Pslverr  = 3'b000;

        //               rst  trans wr  haddr          hwdata         prdy    perr    rdy  resp   psel    pen  hrdata         paddr          pw   pwdata
        // reset and idle
        tbl[0]  = mk(1'b1, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
        // read slave 1, zero wait states
        tbl[2]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_1004, 32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b010, 1'b0, 32'h0,         32'h8000_1004, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b010, 1'b1, 32'h0,         32'h8000_1004, 1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_1004, 1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_1004, 1'b0, 32'h0);
        // write slave 2, Pready[2] low for three ACCESS cycles
        tbl[6]  = mk(1'b0, 2'd2, 1'b1, 32'h8000_2010, 32'h0,         3'b011, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h0);
        tbl[7]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h1234_5678, 3'b011, 3'b000, 1'b0, 2'd0, 3'b100, 1'b0, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[8]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b011, 3'b000, 1'b0, 2'd0, 3'b100, 1'b1, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[9]  = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b011, 3'b000, 1'b0, 2'd0, 3'b100, 1'b1, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[10] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b011, 3'b000, 1'b0, 2'd0, 3'b100, 1'b1, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[11] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b011, 3'b000, 1'b0, 2'd0, 3'b100, 1'b1, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[12] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        tbl[13] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_2010, 1'b1, 32'h1234_5678);
        // read slave 0 with Pslverr: ERR1 then ERR2, Hrdata held
        tbl[14] = mk(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,         3'b111, 3'b001, 1'b0, 2'd0, 3'b001, 1'b0, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 32'h1234_5678);
        tbl[15] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b001, 1'b0, 2'd0, 3'b001, 1'b1, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 32'h1234_5678);
        tbl[16] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b001, 1'b0, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 32'h1234_5678);
        tbl[17] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 32'h1234_5678);
        tbl[18] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_0008, 1'b0, 32'h1234_5678);
        // decode miss just past the last slave window
        tbl[19] = mk(1'b0, 2'd2, 1'b0, 32'h8000_3000, 32'h0,         3'b111, 3'b000, 1'b0, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_3000, 1'b0, 32'h1234_5678);
        tbl[20] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_3000, 1'b0, 32'h1234_5678);
        tbl[21] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_3000, 1'b0, 32'h1234_5678);
        // BUSY ignored
        tbl[22] = mk(1'b0, 2'd1, 1'b0, 32'h8000_1000, 32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h8000_3000, 1'b0, 32'h1234_5678);
        // miss just below the base; request held during ERR1 is not taken
        tbl[23] = mk(1'b0, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h0,         3'b111, 3'b000, 1'b0, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h7FFF_FFFC, 1'b0, 32'h1234_5678);
        tbl[24] = mk(1'b0, 2'd2, 1'b0, 32'h8000_2FFC, 32'h0,         3'b111, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0, 32'hDEAD_BEEF, 32'h7FFF_FFFC, 1'b0, 32'h1234_5678);
        // taken in ERR2: SETUP with no idle bubble, last word of slave 2
        tbl[25] = mk(1'b0, 2'd2, 1'b0, 32'h8000_2FFC, 32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b100, 1'b0, 32'hDEAD_BEEF, 32'h8000_2FFC, 1'b0, 32'h1234_5678);
        tbl[26] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b100, 1'b1, 32'hDEAD_BEEF, 32'h8000_2FFC, 1'b0, 32'h1234_5678);
        tbl[27] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h2222_2222, 32'h8000_2FFC, 1'b0, 32'h1234_5678);
        // SEQ write taken in DONE
        tbl[28] = mk(1'b0, 2'd3, 1'b1, 32'h8000_0000, 32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b000, 1'b0, 32'h2222_2222, 32'h8000_0000, 1'b1, 32'h1234_5678);
        tbl[29] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'hCAFE_F00D, 3'b111, 3'b000, 1'b0, 2'd0, 3'b001, 1'b0, 32'h2222_2222, 32'h8000_0000, 1'b1, 32'hCAFE_F00D);
        tbl[30] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b0, 2'd0, 3'b001, 1'b1, 32'h2222_2222, 32'h8000_0000, 1'b1, 32'hCAFE_F00D);
        tbl[31] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h2222_2222, 32'h8000_0000, 1'b1, 32'hCAFE_F00D);
        // read taken in DONE, stalls, then reset during ACCESS
        tbl[32] = mk(1'b0, 2'd2, 1'b0, 32'h8000_1000, 32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b010, 1'b0, 32'h2222_2222, 32'h8000_1000, 1'b0, 32'hCAFE_F00D);
        tbl[33] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b010, 1'b1, 32'h2222_2222, 32'h8000_1000, 1'b0, 32'hCAFE_F00D);
        tbl[34] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b010, 1'b1, 32'h2222_2222, 32'h8000_1000, 1'b0, 32'hCAFE_F00D);
        tbl[35] = mk(1'b1, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
        tbl[36] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
        // timeout: four ACCESS cycles without Pready, then ERR1/ERR2
        tbl[37] = mk(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 1'b0, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[38] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 1'b1, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[39] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 1'b1, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[40] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 1'b1, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[41] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd0, 3'b001, 1'b1, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[42] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b0, 2'd1, 3'b000, 1'b0, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[43] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b000, 3'b000, 1'b1, 2'd1, 3'b000, 1'b0, 32'h0,         32'h8000_0100, 1'b0, 32'h0);
        tbl[44] = mk(1'b0, 2'd0, 1'b0, 32'h0,          32'h0,         3'b111, 3'b000, 1'b1, 2'd0, 3'b000, 1'b0, 32'h0,         32'h8000_0100, 1'b0, 32'h0);

        for (int k = 0; k < NV; k++) begin
            Hreset  = tbl[k].rst;
            Htrans  = tbl[k].htrans;
            Hwrite  = tbl[k].hwrite;
            Haddr   = tbl[k].haddr;
            Hwdata  = tbl[k].hwdata;
            Pready  = tbl[k].pready;
            Pslverr = tbl[k].pslverr;
            tick();
            check($sformatf("v%0d.hreadyout", k), 32'(Hreadyout), 32'(tbl[k].e_ready));
            check($sformatf("v%0d.hresp", k),     32'(Hresp),     32'(tbl[k].e_resp));
            check($sformatf("v%0d.pselx", k),     32'(Pselx),     32'(tbl[k].e_psel));
            check($sformatf("v%0d.penable", k),   32'(Penable),   32'(tbl[k].e_pen));
            check($sformatf("v%0d.hrdata", k),    Hrdata,         tbl[k].e_hrdata);
            check($sformatf("v%0d.paddr", k),     Paddr,          tbl[k].e_paddr);
            check($sformatf("v%0d.pwrite", k),    32'(Pwrite),    32'(tbl[k].e_pwrite));
            check($sformatf("v%0d.pwdata", k),    Pwdata,         tbl[k].e_pwdata);
        end

        // Write decode miss: straight to ERR1 (no WDATA), ready returns after one more cycle.
        Hreset  = 1'b0;
        Htrans  = 2'b10;
        Hwrite  = 1'b1;
        Haddr   = 32'h8000_3000;
        Pready  = 3'b111;
        Pslverr = 3'b000;
        tick();
        Htrans  = 2'b00;
        Hwrite  = 1'b0;
        check("wmiss.err1_ready", 32'(Hreadyout), 32'd0);
        check("wmiss.err1_resp",  32'(Hresp),     32'd1);
        check("wmiss.err1_psel",  32'(Pselx),     32'd0);
        n = 0;
        while (Hreadyout !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("wmiss.wait_cycles", 32'(n), 32'd1);
        check("wmiss.err2_resp",   32'(Hresp), 32'd1);
        check("wmiss.pwdata_kept", Pwdata,    32'h0);
        tick();
        check("wmiss.idle_resp",   32'(Hresp),     32'd0);
        check("wmiss.idle_ready",  32'(Hreadyout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
